axis_i2c_arbiter: RTL and testbench

AXIS_I2C_ARBITER -- requirements
Module: axis_i2c_arbiter

---
 rtl/axis_i2c_pkg.sv | 18 +
 rtl/axis_i2c_rr_pick.sv | 30 +++
 rtl/axis_i2c_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axis_i2c_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_i2c_pkg.sv
// Shared widths, command encoding and arbiter state type
// for the AXIS-to-I2C command arbiter.
package axis_i2c_pkg;

   localparam int AXIS_DATA_WIDTH = 16;
   localparam int I2C_DATA_WIDTH  = 8;
   localparam int I2C_RW_BIT      = 0;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      SEND = 2'd1,
      BUSY = 2'd2
   } arb_state_t;

endpackage

// File: rtl/axis_i2c_rr_pick.sv
// Round-robin winner search: first asserted request
// strictly after last_i, wrapping around.
module axis_i2c_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic          any_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin : pick
      logic found;
      int   k;
      found = 1'b0;
      k     = 0;
      idx_o = '0;
      for (int i = 1; i <= N; i++) begin
         k = (int'(last_i) + i) % N;
         if (!found && req_i[k]) begin
            found = 1'b1;
            idx_o = IW'(k);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among AXIS requesters.
// Define AXIS_I2C_ARB_TIMEOUT_EN to enable the SEND/BUSY watchdog.
module axis_i2c_arbiter
   import axis_i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 req_tvalid_i,
   input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] req_tdata_i,
   output logic [NUM_REQ-1:0]                 req_tready_o,
   output logic                               m_tvalid_o,
   output logic [AXIS_DATA_WIDTH-1:0]         m_tdata_o,
   input  logic                               m_tready_i,
   input  logic [I2C_DATA_WIDTH-1:0]          i2c_rdata_i,
   input  logic                               i2c_rvalid_i,
   output logic [I2C_DATA_WIDTH-1:0]          rsp_rdata_o,
   output logic [NUM_REQ-1:0]                 rsp_valid_o,
   output logic [NUM_REQ-1:0]                 done_o,
   output logic [$clog2(NUM_REQ)-1:0]         grant_id_o,
   output logic                               busy_o,
   output logic                               timeout_o
);

   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_t state_q, state_d;

   logic [IW-1:0]              last_q;
   logic [IW-1:0]              owner_q;
   logic [AXIS_DATA_WIDTH-1:0] cmd_q;
   logic                       first_q;
   logic [NUM_REQ-1:0]         done_q;
   logic [NUM_REQ-1:0]         rsp_valid_q;
   logic [I2C_DATA_WIDTH-1:0]  rsp_data_q;
   logic                       tmo_q;

   logic               any;
   logic [IW-1:0]      win;
   logic [NUM_REQ-1:0] tready;
   logic [NUM_REQ-1:0] owner_oh;
   logic               take;
   logic               finish;
   logic               tmo;

   axis_i2c_rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i  (req_tvalid_i),
      .last_i (last_q),
      .any_o  (any),
      .idx_o  (win)
   );

   assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef AXIS_I2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] wd_q;

   assign tmo = (state_q != ARB) &&
                (wd_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || state_q == ARB || tmo) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + CW'(1);
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tready  = '0;
      take    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         ARB: begin
            if (any) begin
               take        = 1'b1;
               tready[win] = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (m_tready_i) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            // master ready may still be stale on the first BUSY cycle
            if (!first_q && m_tready_i) begin
               finish  = 1'b1;
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
      if (tmo) begin
         state_d = ARB;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q      <= IW'(NUM_REQ - 1);
         owner_q     <= '0;
         cmd_q       <= '0;
         first_q     <= 1'b0;
         done_q      <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         tmo_q       <= 1'b0;
      end else begin
         first_q <= (state_q == SEND);
         tmo_q   <= tmo;
         done_q  <= (finish || tmo) ? owner_oh : '0;
         if (take) begin
            owner_q <= win;
            last_q  <= win;
            cmd_q   <= req_tdata_i[int'(win)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
         end
         if (state_q == BUSY && i2c_rvalid_i) begin
            rsp_valid_q <= owner_oh;
            rsp_data_q  <= i2c_rdata_i;
         end else begin
            rsp_valid_q <= '0;
         end
      end
   end

   assign req_tready_o = tready;
   assign m_tvalid_o   = (state_q == SEND);
   assign m_tdata_o    = cmd_q;
   assign rsp_rdata_o  = rsp_data_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign done_o       = done_q;
   assign grant_id_o   = owner_q;
   assign busy_o       = (state_q != ARB);
   assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed self-checking bench for axis_i2c_arbiter
// (timeout steps active when AXIS_I2C_ARB_TIMEOUT_EN is defined).
module tb_axis_i2c_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic [3:0]  req_tvalid_i;
   logic [63:0] req_tdata_i;
   logic [3:0]  req_tready_o;
   logic        m_tvalid_o;
   logic [15:0] m_tdata_o;
   logic        m_tready_i;
   logic [7:0]  i2c_rdata_i;
   logic        i2c_rvalid_i;
   logic [7:0]  rsp_rdata_o;
   logic [3:0]  rsp_valid_o;
   logic [3:0]  done_o;
   logic [1:0]  grant_id_o;
   logic        busy_o;
   logic        timeout_o;

   int n_chk  = 0;
   int n_fail = 0;

   axis_i2c_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_tvalid_i (req_tvalid_i),
      .req_tdata_i  (req_tdata_i),
      .req_tready_o (req_tready_o),
      .m_tvalid_o   (m_tvalid_o),
      .m_tdata_o    (m_tdata_o),
      .m_tready_i   (m_tready_i),
      .i2c_rdata_i  (i2c_rdata_i),
      .i2c_rvalid_i (i2c_rvalid_i),
      .rsp_rdata_o  (rsp_rdata_o),
      .rsp_valid_o  (rsp_valid_o),
      .done_o       (done_o),
      .grant_id_o   (grant_id_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction starting from a negedge in ARB where
   // requester `who` is the expected winner; ends at a negedge in ARB.
   task automatic xact(input int who, input logic [15:0] data,
                       input bit keep, input bit rd,
                       input logic [7:0] rdata);
      logic [3:0] oh;
      oh = 4'b0001 << who;
      #1;
      chk("grant_tready", 32'(req_tready_o), 32'(oh));
      step();
      if (!keep) req_tvalid_i[who] = 1'b0;
      #1;
      chk("m_tvalid", 32'(m_tvalid_o), 32'd1);
      chk("m_tdata", 32'(m_tdata_o), 32'(data));
      chk("grant_id", 32'(grant_id_o), 32'(who));
      chk("tready_send", 32'(req_tready_o), 32'd0);
      step();
      m_tready_i = 1'b0;
      if (rd) begin
         i2c_rvalid_i = 1'b1;
         i2c_rdata_i  = rdata;
      end
      step();
      i2c_rvalid_i = 1'b0;
      if (rd) begin
         chk("rsp_valid", 32'(rsp_valid_o), 32'(oh));
         chk("rsp_rdata", 32'(rsp_rdata_o), 32'(rdata));
      end
      chk("busy_in_busy", 32'(busy_o), 32'd1);
      chk("done_early", 32'(done_o), 32'd0);
      m_tready_i = 1'b1;
      step();
      chk("done", 32'(done_o), 32'(oh));
      chk("busy_after", 32'(busy_o), 32'd0);
   endtask

   initial begin
      int  n;
      bit  seen;
      rst_i        = 1'b1;
      req_tvalid_i = '0;
      req_tdata_i  = {16'h4400, 16'h00A1, 16'h2200, 16'h5AA0};
      m_tready_i   = 1'b1;
      i2c_rdata_i  = '0;
      i2c_rvalid_i = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
      chk("rst_tready", 32'(req_tready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata_o), 32'd0);
      chk("rst_grant_id", 32'(grant_id_o), 32'd0);
      rst_i = 1'b0;

      // single write from requester 0
      req_tvalid_i = 4'b0001;
      xact(0, 16'h5AA0, 0, 0, 8'h00);

      // master ready held high: first BUSY cycle must be ignored
      req_tvalid_i = 4'b1000;
      #1;
      chk("hold_tready", 32'(req_tready_o), 32'b1000);
      step();
      req_tvalid_i = 4'b0000;
      step();
      chk("hold_busy1", 32'(busy_o), 32'd1);
      step();
      chk("hold_busy2", 32'(busy_o), 32'd1);
      chk("hold_done_early", 32'(done_o), 32'd0);
      step();
      chk("hold_done", 32'(done_o), 32'b1000);
      chk("hold_idle", 32'(busy_o), 32'd0);

      // all requesters valid continuously: 0,1,2,3,0
      req_tvalid_i = 4'b1111;
      xact(0, 16'h5AA0, 1, 0, 8'h00);
      xact(1, 16'h2200, 1, 0, 8'h00);
      xact(2, 16'h00A1, 1, 0, 8'h00);
      xact(3, 16'h4400, 1, 0, 8'h00);
      xact(0, 16'h5AA0, 1, 0, 8'h00);
      req_tvalid_i = 4'b0000;

      // read from requester 2
      req_tvalid_i = 4'b0100;
      xact(2, 16'h00A1, 0, 1, 8'h3C);

      // spurious read-data valid in ARB
      i2c_rvalid_i = 1'b1;
      i2c_rdata_i  = 8'h77;
      step();
      i2c_rvalid_i = 1'b0;
      chk("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("spur_rdata_hold", 32'(rsp_rdata_o), 32'h3C);

      // requester 0 withdraws before its turn and is skipped
      req_tvalid_i = 4'b1001;
      xact(3, 16'h4400, 0, 0, 8'h00);
      req_tvalid_i = 4'b0010;
      xact(1, 16'h2200, 0, 0, 8'h00);

`ifdef AXIS_I2C_ARB_TIMEOUT_EN
      // stuck master: watchdog aborts requester 2, then 3 is served
      req_tvalid_i = 4'b1100;
      m_tready_i   = 1'b0;
      #1;
      chk("to_tready", 32'(req_tready_o), 32'b0100);
      step();
      req_tvalid_i[2] = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         step();
         n++;
         seen = timeout_o;
      end
      chk("to_delay", 32'(n), 32'd16);
      chk("to_done", 32'(done_o), 32'b0100);
      chk("to_idle", 32'(busy_o), 32'd0);
      m_tready_i = 1'b1;
      xact(3, 16'h4400, 0, 0, 8'h00);
      chk("to_pulse_end", 32'(timeout_o), 32'd0);
`else
      // no watchdog: a stuck master is waited on indefinitely
      req_tvalid_i = 4'b0100;
      m_tready_i   = 1'b0;
      #1;
      chk("wait_tready", 32'(req_tready_o), 32'b0100);
      step();
      req_tvalid_i = 4'b0000;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         seen = seen | timeout_o;
      end
      chk("wait_no_timeout", 32'(seen), 32'd0);
      chk("wait_m_tvalid", 32'(m_tvalid_o), 32'd1);
      m_tready_i = 1'b1;
      step();
      step();
      step();
      chk("wait_done", 32'(done_o), 32'b0100);
`endif

      // reset in BUSY abandons the owner
      req_tvalid_i = 4'b0010;
      #1;
      chk("mid_tready", 32'(req_tready_o), 32'b0010);
      step();
      req_tvalid_i = 4'b0000;
      step();
      m_tready_i = 1'b0;
      step();
      chk("mid_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      step();
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_done", 32'(done_o), 32'd0);
      chk("mid_rst_gid", 32'(grant_id_o), 32'd0);
      rst_i      = 1'b0;
      m_tready_i = 1'b1;
      req_tvalid_i = 4'b1111;
      xact(0, 16'h5AA0, 0, 0, 8'h00);
      req_tvalid_i = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
